// File: rtl/mcb_arb2.sv
// mcb_arb2: two-port SDR SDRAM command arbiter with in-order write/read data routing.
// Optional build macro MCB_ARB_P0_PRIO_EN: port 0 has fixed priority when both ports
// request, with a port-1 anti-starvation counter (8 back-to-back port-0 grants max).
module mcb_arb2 #(
  parameter int unsigned B_W       = 2,
  parameter int unsigned R_W       = 13,
  parameter int unsigned C_W       = 9,
  parameter int unsigned D_W       = 32,
  parameter int unsigned BE_W      = 4,
  parameter int unsigned TAG_DEPTH = 4
) (
  input  logic            mcb_clk,
  input  logic            mcb_rst_n,
  input  logic            mcb_sclr_n,
  input  logic            p0_req,
  input  logic            p0_wr_n,
  input  logic [1:0]      p0_bl,
  input  logic [B_W-1:0]  p0_ba,
  input  logic [R_W-1:0]  p0_ra,
  input  logic [C_W-1:0]  p0_ca,
  output logic            p0_ack,
  input  logic [D_W-1:0]  p0_wdat,
  input  logic [BE_W-1:0] p0_wbe,
  output logic            p0_wdat_req,
  output logic [D_W-1:0]  p0_rdat,
  output logic            p0_rdat_vld,
  input  logic            p1_req,
  input  logic            p1_wr_n,
  input  logic [1:0]      p1_bl,
  input  logic [B_W-1:0]  p1_ba,
  input  logic [R_W-1:0]  p1_ra,
  input  logic [C_W-1:0]  p1_ca,
  output logic            p1_ack,
  input  logic [D_W-1:0]  p1_wdat,
  input  logic [BE_W-1:0] p1_wbe,
  output logic            p1_wdat_req,
  output logic [D_W-1:0]  p1_rdat,
  output logic            p1_rdat_vld,
  output logic            m_bb,
  output logic            m_wr_n,
  output logic [1:0]      m_bl,
  output logic [B_W-1:0]  m_ba,
  output logic [R_W-1:0]  m_ra,
  output logic [C_W-1:0]  m_ca,
  input  logic            m_busy,
  input  logic            m_i_ready,
  input  logic            m_wdat_req,
  output logic [D_W-1:0]  m_wdat,
  output logic [BE_W-1:0] m_wbe,
  input  logic            m_rdat_vld,
  input  logic [D_W-1:0]  m_rdat
);

  localparam int unsigned PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  // Owner, direction and last beat index of one issued burst.
  typedef struct packed {
    logic       port;
    logic       wr_n;
    logic [2:0] last_beat;
  } tag_t;

  tag_t             tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] occ;
  logic [2:0]       beat_cnt;

  logic             issue_c;
  logic             win_c;
  logic [1:0]       sel_bl_c;
  tag_t             new_tag_c;
  tag_t             head_c;
  logic             head_vld_c;
  logic             wr_beat_c;
  logic             rd_beat_c;
  logic             pop_c;

`ifdef MCB_ARB_P0_PRIO_EN
  logic [3:0] starve_q;

  // Counts port-0 grants taken while port 1 was waiting.
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n)       starve_q <= 4'd0;
    else if (!mcb_sclr_n) starve_q <= 4'd0;
    else if (issue_c)     starve_q <= (!win_c && p1_req) ? starve_q + 4'd1 : 4'd0;
  end
`else
  logic last_win_q;

  // Last granted port; starts at 1 so port 0 wins the first contested slot.
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n)       last_win_q <= 1'b1;
    else if (!mcb_sclr_n) last_win_q <= 1'b1;
    else if (issue_c)     last_win_q <= win_c;
  end
`endif

  // Issue decision, winner selection and the tag describing the winner's burst.
  always_comb begin
    issue_c = m_i_ready && !m_busy && (occ != CNT_W'(TAG_DEPTH)) && !m_bb && (p0_req || p1_req);
`ifdef MCB_ARB_P0_PRIO_EN
    win_c = p1_req && (!p0_req || (starve_q == 4'd8));
`else
    win_c = p1_req && (!p0_req || !last_win_q);
`endif
    sel_bl_c            = win_c ? p1_bl : p0_bl;
    new_tag_c.port      = win_c;
    new_tag_c.wr_n      = win_c ? p1_wr_n : p0_wr_n;
    new_tag_c.last_beat = 3'((4'd1 << sel_bl_c) - 4'd1);
  end

  // Steer back-end data beats to the owner of the head tag.
  always_comb begin
    head_c      = tag_mem[rd_ptr];
    head_vld_c  = mcb_sclr_n && (occ != '0);
    wr_beat_c   = head_vld_c && !head_c.wr_n && m_wdat_req;
    rd_beat_c   = head_vld_c && head_c.wr_n && m_rdat_vld;
    pop_c       = (wr_beat_c || rd_beat_c) && (beat_cnt == head_c.last_beat);
    p0_wdat_req = wr_beat_c && !head_c.port;
    p1_wdat_req = wr_beat_c && head_c.port;
    p0_rdat_vld = rd_beat_c && !head_c.port;
    p1_rdat_vld = rd_beat_c && head_c.port;
    p0_rdat     = m_rdat;
    p1_rdat     = m_rdat;
    m_wdat      = '0;
    m_wbe       = '0;
    if (head_vld_c && !head_c.wr_n) begin
      m_wdat = head_c.port ? p1_wdat : p0_wdat;
      m_wbe  = head_c.port ? p1_wbe  : p0_wbe;
    end
  end

  // Tag storage; validity is tracked by the pointers and occupancy.
  always_ff @(posedge mcb_clk) begin
    if (issue_c) tag_mem[wr_ptr] <= new_tag_c;
  end

  // Command outputs, queue pointers and head beat counter.
  always_ff @(posedge mcb_clk or negedge mcb_rst_n) begin
    if (!mcb_rst_n) begin
      m_bb <= 1'b0; p0_ack <= 1'b0; p1_ack <= 1'b0;
      m_wr_n <= 1'b1; m_bl <= '0; m_ba <= '0; m_ra <= '0; m_ca <= '0;
      rd_ptr <= '0; wr_ptr <= '0; occ <= '0; beat_cnt <= '0;
    end else if (!mcb_sclr_n) begin
      m_bb <= 1'b0; p0_ack <= 1'b0; p1_ack <= 1'b0;
      m_wr_n <= 1'b1; m_bl <= '0; m_ba <= '0; m_ra <= '0; m_ca <= '0;
      rd_ptr <= '0; wr_ptr <= '0; occ <= '0; beat_cnt <= '0;
    end else begin
      m_bb   <= issue_c;
      p0_ack <= issue_c && !win_c;
      p1_ack <= issue_c && win_c;
      if (issue_c) begin
        m_wr_n <= new_tag_c.wr_n;
        m_bl   <= sel_bl_c;
        m_ba   <= win_c ? p1_ba : p0_ba;
        m_ra   <= win_c ? p1_ra : p0_ra;
        m_ca   <= win_c ? p1_ca : p0_ca;
        wr_ptr <= PTR_W'(wr_ptr + 1'b1);
      end
      if (pop_c) rd_ptr <= PTR_W'(rd_ptr + 1'b1);
      occ <= occ + CNT_W'(issue_c) - CNT_W'(pop_c);
      if (pop_c)                       beat_cnt <= '0;
      else if (wr_beat_c || rd_beat_c) beat_cnt <= beat_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_mcb_arb2.sv
// tb_mcb_arb2: randomized bench for mcb_arb2 against a queue-based reference model.
// Build with +define+MCB_ARB_P0_PRIO_EN to check the port-0 priority variant.
module tb_mcb_arb2;

  localparam int unsigned B_W = 2, R_W = 13, C_W = 9, D_W = 32, BE_W = 4, DEPTH = 4;

  logic mcb_clk = 1'b0;
  logic mcb_rst_n, mcb_sclr_n;
  logic p0_req, p0_wr_n, p0_ack, p0_wdat_req, p0_rdat_vld;
  logic p1_req, p1_wr_n, p1_ack, p1_wdat_req, p1_rdat_vld;
  logic [1:0] p0_bl, p1_bl, m_bl;
  logic [B_W-1:0] p0_ba, p1_ba, m_ba;
  logic [R_W-1:0] p0_ra, p1_ra, m_ra;
  logic [C_W-1:0] p0_ca, p1_ca, m_ca;
  logic [D_W-1:0] p0_wdat, p1_wdat, p0_rdat, p1_rdat, m_wdat, m_rdat;
  logic [BE_W-1:0] p0_wbe, p1_wbe, m_wbe;
  logic m_bb, m_wr_n, m_busy, m_i_ready, m_wdat_req, m_rdat_vld;

  // Requester-side stimulus, one slot per port.
  logic            req [2];
  logic            wr_n [2];
  logic [1:0]      bl [2];
  logic [B_W-1:0]  ba [2];
  logic [R_W-1:0]  ra [2];
  logic [C_W-1:0]  ca [2];
  logic [D_W-1:0]  wdat [2];
  logic [BE_W-1:0] wbe [2];

  assign p0_req = req[0];  assign p1_req = req[1];
  assign p0_wr_n = wr_n[0]; assign p1_wr_n = wr_n[1];
  assign p0_bl = bl[0];    assign p1_bl = bl[1];
  assign p0_ba = ba[0];    assign p1_ba = ba[1];
  assign p0_ra = ra[0];    assign p1_ra = ra[1];
  assign p0_ca = ca[0];    assign p1_ca = ca[1];
  assign p0_wdat = wdat[0]; assign p1_wdat = wdat[1];
  assign p0_wbe = wbe[0];  assign p1_wbe = wbe[1];

  mcb_arb2 #(.B_W(B_W), .R_W(R_W), .C_W(C_W), .D_W(D_W), .BE_W(BE_W), .TAG_DEPTH(DEPTH)) dut (
    .mcb_clk(mcb_clk), .mcb_rst_n(mcb_rst_n), .mcb_sclr_n(mcb_sclr_n),
    .p0_req(p0_req), .p0_wr_n(p0_wr_n), .p0_bl(p0_bl), .p0_ba(p0_ba), .p0_ra(p0_ra),
    .p0_ca(p0_ca), .p0_ack(p0_ack), .p0_wdat(p0_wdat), .p0_wbe(p0_wbe),
    .p0_wdat_req(p0_wdat_req), .p0_rdat(p0_rdat), .p0_rdat_vld(p0_rdat_vld),
    .p1_req(p1_req), .p1_wr_n(p1_wr_n), .p1_bl(p1_bl), .p1_ba(p1_ba), .p1_ra(p1_ra),
    .p1_ca(p1_ca), .p1_ack(p1_ack), .p1_wdat(p1_wdat), .p1_wbe(p1_wbe),
    .p1_wdat_req(p1_wdat_req), .p1_rdat(p1_rdat), .p1_rdat_vld(p1_rdat_vld),
    .m_bb(m_bb), .m_wr_n(m_wr_n), .m_bl(m_bl), .m_ba(m_ba), .m_ra(m_ra), .m_ca(m_ca),
    .m_busy(m_busy), .m_i_ready(m_i_ready), .m_wdat_req(m_wdat_req), .m_wdat(m_wdat),
    .m_wbe(m_wbe), .m_rdat_vld(m_rdat_vld), .m_rdat(m_rdat)
  );

  always #5 mcb_clk = ~mcb_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: a queue of outstanding bursts with beats still owed.
  typedef struct { int port; bit rd; int left; } mtag_t;
  mtag_t mq[$];
  bit e_bb, e_ack0, e_ack1, e_wr_n, beat;
  logic [1:0] e_bl;
  logic [B_W-1:0] e_ba;
  logic [R_W-1:0] e_ra;
  logic [C_W-1:0] e_ca;
  bit e_wreq [2];
  bit e_rvld [2];
  logic [D_W-1:0] e_wdat;
  logic [BE_W-1:0] e_wbe;
  int last_win, p0_run;
  bit prev_bb;

  task automatic model_reset();
    mq.delete();
    e_bb = 0; e_ack0 = 0; e_ack1 = 0; e_wr_n = 1;
    e_bl = '0; e_ba = '0; e_ra = '0; e_ca = '0;
    last_win = 1; p0_run = 0;
  endtask

  // Expected routing for the inputs currently applied.
  task automatic model_comb();
    mtag_t h;
    e_wreq[0] = 0; e_wreq[1] = 0; e_rvld[0] = 0; e_rvld[1] = 0;
    e_wdat = '0; e_wbe = '0; beat = 0;
    if (mcb_sclr_n && mq.size() > 0) begin
      h = mq[0];
      if (!h.rd) begin
        e_wdat = wdat[h.port]; e_wbe = wbe[h.port];
        if (m_wdat_req) begin e_wreq[h.port] = 1; beat = 1; end
      end else if (m_rdat_vld) begin
        e_rvld[h.port] = 1; beat = 1;
      end
    end
  endtask

  // Advance the model across one rising edge.
  task automatic model_seq();
    mtag_t h;
    bit issue;
    int w;
    if (!mcb_sclr_n) begin
      model_reset();
      return;
    end
    issue = m_i_ready && !m_busy && (mq.size() < DEPTH) && !e_bb && (req[0] || req[1]);
    if (beat) begin
      h = mq[0];
      h.left = h.left - 1;
      if (h.left == 0) void'(mq.pop_front());
      else mq[0] = h;
    end
    e_ack0 = 0; e_ack1 = 0; e_bb = 0;
    if (issue) begin
`ifdef MCB_ARB_P0_PRIO_EN
      if (req[0] && req[1]) w = (p0_run >= 8) ? 1 : 0;
      else w = req[1] ? 1 : 0;
      p0_run = (w == 0 && req[1]) ? p0_run + 1 : 0;
`else
      if (req[0] && req[1]) w = 1 - last_win;
      else w = req[1] ? 1 : 0;
      last_win = w;
`endif
      e_bb = 1;
      if (w == 0) e_ack0 = 1; else e_ack1 = 1;
      e_wr_n = wr_n[w]; e_bl = bl[w]; e_ba = ba[w]; e_ra = ra[w]; e_ca = ca[w];
      mq.push_back('{w, wr_n[w], 1 << bl[w]});
    end
  endtask

  task automatic check_regs();
    chk("m_bb", m_bb, e_bb);
    chk("p0_ack", p0_ack, e_ack0);
    chk("p1_ack", p1_ack, e_ack1);
    chk("m_wr_n", m_wr_n, e_wr_n);
    chk("m_bl", m_bl, e_bl);
    chk("m_ba", m_ba, e_ba);
    chk("m_ra", m_ra, e_ra);
    chk("m_ca", m_ca, e_ca);
    chk("bb_adjacent", prev_bb & m_bb, 0);
    prev_bb = m_bb;
  endtask

  task automatic check_comb(input logic [D_W-1:0] rdat_drv);
    chk("p0_wdat_req", p0_wdat_req, e_wreq[0]);
    chk("p1_wdat_req", p1_wdat_req, e_wreq[1]);
    chk("p0_rdat_vld", p0_rdat_vld, e_rvld[0]);
    chk("p1_rdat_vld", p1_rdat_vld, e_rvld[1]);
    chk("m_wdat", m_wdat, e_wdat);
    chk("m_wbe", m_wbe, e_wbe);
    chk("p0_rdat", p0_rdat, rdat_drv);
    chk("p1_rdat", p1_rdat, rdat_drv);
  endtask

  // Modes: 0 random, 1 both ports always requesting, 2 reads with no data return, 3 directed.
  task automatic gen_inputs(input int mode);
    bit dropped;
    for (int n = 0; n < 2; n++) begin
      dropped = 0;
      if (req[n] && ((n == 0) ? e_ack0 : e_ack1)) req[n] = 0;
      else if (req[n] && mode == 0 && $urandom_range(0, 99) < 4) begin req[n] = 0; dropped = 1; end
      if (!req[n] && !dropped && mode != 3 &&
          (mode != 0 || $urandom_range(0, 99) < 30)) begin
        req[n] = 1;
        wr_n[n] = (mode == 2) ? 1'b1 : 1'($urandom_range(0, 1));
        bl[n] = 2'($urandom_range(0, 3));
        ba[n] = B_W'($urandom); ra[n] = R_W'($urandom); ca[n] = C_W'($urandom);
      end
      wdat[n] = $urandom; wbe[n] = BE_W'($urandom);
    end
    m_rdat     = $urandom;
    m_i_ready  = (mode == 0) ? ($urandom_range(0, 99) < 95) : 1'b1;
    m_busy     = (mode == 0) ? ($urandom_range(0, 99) < 20) : 1'b0;
    m_wdat_req = (mode == 2) ? 1'b0 : (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    m_rdat_vld = (mode == 2) ? 1'b0 : (mode == 0) ? 1'($urandom_range(0, 1)) : 1'b1;
    mcb_sclr_n = (mode == 0) ? ($urandom_range(0, 99) >= 2) : 1'b1;
  endtask

  int p0_rv_cnt, p1_rv_cnt, bb_cnt;

  task automatic run(input int mode, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      check_regs();
      gen_inputs(mode);
      #1;
      model_comb();
      check_comb(m_rdat);
      if (p0_rdat_vld) p0_rv_cnt++;
      if (p1_rdat_vld) p1_rv_cnt++;
      model_seq();
      @(negedge mcb_clk);
    end
  endtask

  initial begin
    for (int n = 0; n < 2; n++) begin
      req[n] = 0; wr_n[n] = 1; bl[n] = '0; ba[n] = '0; ra[n] = '0; ca[n] = '0;
      wdat[n] = '0; wbe[n] = '0;
    end
    m_busy = 0; m_i_ready = 0; m_wdat_req = 0; m_rdat_vld = 0; m_rdat = '0;
    mcb_sclr_n = 1; mcb_rst_n = 0; prev_bb = 0;
    p0_rv_cnt = 0; p1_rv_cnt = 0; bb_cnt = 0;
    model_reset();
    repeat (3) @(negedge mcb_clk);
    chk("rst_m_bb", m_bb, 0);
    chk("rst_m_wr_n", m_wr_n, 1);
    chk("rst_acks", {p0_ack, p1_ack}, 0);
    chk("rst_fields", {m_bl, m_ba, m_ra, m_ca}, 0);
    chk("rst_routing", {p0_wdat_req, p1_wdat_req, p0_rdat_vld, p1_rdat_vld}, 0);
    chk("rst_m_wdat", m_wdat, 0);
    mcb_rst_n = 1;

    // Single port-0 read of 4 beats at a fixed address.
    req[0] = 1; wr_n[0] = 1; bl[0] = 2'd2; ba[0] = 2'd1; ra[0] = 13'h123; ca[0] = 9'h040;
    run(3, 12);
    chk("dir_p0_beats", p0_rv_cnt, 4);
    chk("dir_p1_beats", p1_rv_cnt, 0);
    chk("dir_queue_empty", mq.size(), 0);

    run(1, 60);
    run(2, 30);
    run(0, 3000);
    run(1, 60);
    run(2, 20);
    run(0, 500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
